// File: rtl/tilt_pulse_gen.sv
// Tilt-to-pulse generator: converts per-axis sign-magnitude tilt samples (or
// button overrides) into rate-proportional one-cycle move pulses per slot tick.
module tilt_pulse_gen #(
    parameter int CH       = 2,
    parameter int W        = 9,
    parameter int LEVELS   = 4,
    parameter int TICK_DIV = 416667
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CH*W-1:0]   accel_in,
    input  logic [1:0]        sens,
    input  logic [CH-1:0]     btn_pos,
    input  logic [CH-1:0]     btn_neg,
    output logic [CH-1:0]     pulse_pos,
    output logic [CH-1:0]     pulse_neg,
    output logic [CH*4-1:0]   level_out,
    output logic              slot_tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]         count;
    logic [CH-1:0][3:0]    acc;
    logic [CH-1:0][3:0]    acc_next;
    logic [CH-1:0][3:0]    level_q;
    logic [CH-1:0][3:0]    level_next;
    logic [CH-1:0]         dir_q;
    logic [CH-1:0]         dir_next;
    logic [CH-1:0]         fire;
    logic [CH-1:0][W-2:0]  mag_shift;
    logic [CH-1:0][4:0]    sum;
    logic [2:0]            shift;

    assign shift     = 3'd3 + {1'b0, sens};
    assign slot_tick = (count == LAST);
    assign level_out = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A reversal of direction restarts the accumulator before this tick's add.
    always_comb begin
        acc_next   = '0;
        level_next = '0;
        dir_next   = '0;
        fire       = '0;
        mag_shift  = '0;
        sum        = '0;
        for (int c = 0; c < CH; c++) begin
            mag_shift[c] = accel_in[c*W +: W-1] >> shift;
            if (32'(mag_shift[c]) >= LEVELS) begin
                level_next[c] = 4'(LEVELS);
            end else begin
                level_next[c] = 4'(mag_shift[c]);
            end
            dir_next[c] = accel_in[c*W + W-1];
            if (btn_pos[c] != btn_neg[c]) begin
                level_next[c] = 4'(LEVELS);
                dir_next[c]   = btn_neg[c];
            end
            if (dir_next[c] != dir_q[c]) begin
                sum[c] = {1'b0, level_next[c]};
            end else begin
                sum[c] = {1'b0, acc[c]} + {1'b0, level_next[c]};
            end
            if (!enable || level_next[c] == 4'd0) begin
                acc_next[c] = '0;
            end else if (sum[c] >= 5'(LEVELS)) begin
                acc_next[c] = 4'(sum[c] - 5'(LEVELS));
                fire[c]     = 1'b1;
            end else begin
                acc_next[c] = sum[c][3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            dir_q     <= '0;
            level_q   <= '0;
            pulse_pos <= '0;
            pulse_neg <= '0;
        end else begin
            pulse_pos <= '0;
            pulse_neg <= '0;
            if (slot_tick) begin
                acc       <= acc_next;
                dir_q     <= dir_next;
                level_q   <= level_next;
                pulse_pos <= fire & ~dir_next;
                pulse_neg <= fire & dir_next;
            end
        end
    end

endmodule

// File: tb/tb_tilt_pulse_gen.sv
// Self-checking bench for tilt_pulse_gen: a behavioural model feeds an
// expected-value queue that each scenario task drains against observed outputs.
module tb_tilt_pulse_gen;

    localparam int CH       = 2;
    localparam int W        = 9;
    localparam int LEVELS   = 4;
    localparam int TICK_DIV = 4;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [CH*W-1:0]   accel_in;
    logic [1:0]        sens;
    logic [CH-1:0]     btn_pos;
    logic [CH-1:0]     btn_neg;
    logic [CH-1:0]     pulse_pos;
    logic [CH-1:0]     pulse_neg;
    logic [CH*4-1:0]   level_out;
    logic              slot_tick;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];

    int          m_cnt;
    int          m_acc[CH];
    bit          m_dir[CH];
    logic [3:0]  m_lvl[CH];
    logic [CH-1:0] m_pp;
    logic [CH-1:0] m_pn;

    tilt_pulse_gen #(
        .CH(CH), .W(W), .LEVELS(LEVELS), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .accel_in(accel_in),
        .sens(sens), .btn_pos(btn_pos), .btn_neg(btn_neg),
        .pulse_pos(pulse_pos), .pulse_neg(pulse_neg),
        .level_out(level_out), .slot_tick(slot_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model on the current inputs, then clock the DUT
    // and record what it produced.
    task automatic step();
        int mag;
        int lvl;
        bit d;
        bit tk;
        if (reset) begin
            m_cnt = 0;
            m_pp  = '0;
            m_pn  = '0;
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0;
                m_dir[c] = 1'b0;
                m_lvl[c] = 4'd0;
            end
        end else begin
            tk    = (m_cnt == TICK_DIV - 1);
            m_cnt = (m_cnt + 1) % TICK_DIV;
            m_pp  = '0;
            m_pn  = '0;
            if (tk) begin
                for (int c = 0; c < CH; c++) begin
                    mag = int'(accel_in[c*W +: W-1]);
                    lvl = mag >> (3 + int'(sens));
                    d   = accel_in[c*W + W-1];
                    if (lvl > LEVELS) lvl = LEVELS;
                    if (btn_pos[c] != btn_neg[c]) begin
                        lvl = LEVELS;
                        d   = btn_neg[c];
                    end
                    if (!enable || lvl == 0) begin
                        m_acc[c] = 0;
                    end else begin
                        if (d != m_dir[c]) m_acc[c] = 0;
                        m_acc[c] += lvl;
                        if (m_acc[c] >= LEVELS) begin
                            m_acc[c] -= LEVELS;
                            if (d) m_pn[c] = 1'b1;
                            else   m_pp[c] = 1'b1;
                        end
                    end
                    m_dir[c] = d;
                    m_lvl[c] = 4'(lvl);
                end
            end
        end
        exp_q.push_back({m_pp, m_pn, m_lvl[1], m_lvl[0], (m_cnt == TICK_DIV - 1)});
        @(posedge clk);
        #1;
        obs_q.push_back({pulse_pos, pulse_neg, level_out, slot_tick});
    endtask

    task automatic wait_tick();
        int n = 0;
        while (slot_tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (slot_tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick slot_tick=%b required 1 within 8 cycles", slot_tick);
        end
    endtask

    task automatic test_reset();
        logic [12:0] e, o;
        reset = 1'b1; enable = 1'b1; accel_in = '0; sens = 2'd0;
        btn_pos = '0; btn_neg = '0;
        step();
        step();
        checks++;
        if ({pulse_pos, pulse_neg, level_out, slot_tick} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got %h required 0", {pulse_pos, pulse_neg, level_out, slot_tick});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (slot_tick !== (i == 2)) begin
                errors++;
                $display("FAIL first_tick cycle %0d got %b required %b", i, slot_tick, (i == 2));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_reset observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_full_level();
        logic [12:0] e, o;
        logic prev;
        int cnt = 0;
        accel_in = {9'h000, 9'h040};
        for (int i = 0; i < 16; i++) begin
            prev = slot_tick;
            step();
            cnt += int'(pulse_pos[0]);
            checks++;
            if (pulse_pos[0] !== prev) begin
                errors++;
                $display("FAIL full_level_align cycle %0d got %b required %b", i, pulse_pos[0], prev);
            end
        end
        checks++;
        if (cnt != 4 || level_out[3:0] !== 4'd4) begin
            errors++;
            $display("FAIL full_level pulses %0d level %0d required 4 and 4", cnt, level_out[3:0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_full_level observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_level_one();
        logic [12:0] e, o;
        int cnt = 0;
        accel_in = {9'h000, 9'h008};
        repeat (32) begin
            step();
            cnt += int'(pulse_pos[0]);
        end
        checks++;
        if (cnt != 2 || level_out[3:0] !== 4'd1) begin
            errors++;
            $display("FAIL level_one pulses %0d level %0d required 2 and 1", cnt, level_out[3:0]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_level_one observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_sens();
        logic [12:0] e, o;
        logic [1:0]  t_sens[3] = '{2'd1, 2'd3, 2'd0};
        logic [17:0] t_in[3]   = '{{9'h100, 9'h020}, {9'h140, 9'h040}, {9'h0FF, 9'h011}};
        logic [7:0]  t_lvl[3]  = '{8'h02, 8'h11, 8'h42};
        for (int k = 0; k < 3; k++) begin
            sens = t_sens[k];
            accel_in = t_in[k];
            repeat (4) step();
            checks++;
            if (level_out !== t_lvl[k]) begin
                errors++;
                $display("FAIL sens_level entry %0d got %h required %h", k, level_out, t_lvl[k]);
            end
        end
        sens = 2'd0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_sens observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_button();
        logic [12:0] e, o;
        int np = 0, nn = 0;
        accel_in = {9'h110, 9'h000};
        btn_pos = 2'b10; btn_neg = 2'b00;
        repeat (16) begin
            step();
            np += int'(pulse_pos[1]);
            nn += int'(pulse_neg[1]);
        end
        checks++;
        if (np != 4 || nn != 0) begin
            errors++;
            $display("FAIL button_pos pos %0d neg %0d required 4 and 0", np, nn);
        end
        np = 0; nn = 0;
        btn_pos = 2'b10; btn_neg = 2'b10;
        repeat (32) begin
            step();
            np += int'(pulse_pos[1]);
            nn += int'(pulse_neg[1]);
        end
        checks++;
        if (np != 0 || nn != 4) begin
            errors++;
            $display("FAIL button_both pos %0d neg %0d required 0 and 4", np, nn);
        end
        nn = 0;
        btn_pos = 2'b00; btn_neg = 2'b01;
        repeat (8) begin
            step();
            nn += int'(pulse_neg[0]);
        end
        checks++;
        if (nn != 2) begin
            errors++;
            $display("FAIL button_neg_ch0 neg %0d required 2", nn);
        end
        btn_neg = 2'b00;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_button observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_direction_change();
        logic [12:0] e, o;
        accel_in = '0;
        wait_tick(); step();
        accel_in = {9'h000, 9'h018};
        wait_tick(); step();
        checks++;
        if ({pulse_pos[0], pulse_neg[0]} !== 2'b00 || level_out[3:0] !== 4'd3) begin
            errors++;
            $display("FAIL dir_first pulses %b level %0d required 00 and 3", {pulse_pos[0], pulse_neg[0]}, level_out[3:0]);
        end
        accel_in = {9'h000, 9'h118};
        wait_tick(); step();
        checks++;
        if ({pulse_pos[0], pulse_neg[0]} !== 2'b00) begin
            errors++;
            $display("FAIL dir_reverse pulses %b required 00", {pulse_pos[0], pulse_neg[0]});
        end
        wait_tick(); step();
        checks++;
        if ({pulse_pos[0], pulse_neg[0]} !== 2'b01) begin
            errors++;
            $display("FAIL dir_follow pulses %b required 01", {pulse_pos[0], pulse_neg[0]});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_direction observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_enable();
        logic [12:0] e, o;
        int cnt = 0;
        accel_in = {9'h000, 9'h018};
        repeat (12) step();
        enable = 1'b0;
        repeat (10) begin
            step();
            cnt += int'(|pulse_pos) + int'(|pulse_neg);
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL enable_low pulses %0d required 0", cnt);
        end
        enable = 1'b1;
        accel_in = {9'h000, 9'h008};
        cnt = 0;
        repeat (12) begin
            step();
            cnt += int'(pulse_pos[0]);
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL enable_restart pulses %0d required 0", cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_enable observed %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e, o;
        int both = 0;
        accel_in = {9'h040, 9'h040};
        repeat (8) begin
            step();
            both += int'(pulse_pos == 2'b11);
        end
        checks++;
        if (both != 2) begin
            errors++;
            $display("FAIL simultaneous count %0d required 2", both);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({pulse_pos, pulse_neg, level_out, slot_tick} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset got %h required 0", {pulse_pos, pulse_neg, level_out, slot_tick});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (slot_tick !== (i == 2)) begin
                errors++;
                $display("FAIL mid_reset_tick cycle %0d got %b required %b", i, slot_tick, (i == 2));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e || (o[12:11] & o[10:9]) != 2'b00) begin
                errors++;
                $display("FAIL sb_back_to_back observed %h expected %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_level();
        test_level_one();
        test_sens();
        test_button();
        test_direction_change();
        test_enable();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tilt_pulse_gen.md
TILT_PULSE_GEN -- requirements
Module: tilt_pulse_gen

Interface
REQ-001 The block SHALL have parameter CH, default 2, meaning number of independent axes.
REQ-002 The block SHALL have parameter W, default 9, meaning per-axis sample width in sign-magnitude form: bit W-1 is the sign (1 = negative) and bits W-2:0 are the magnitude.
REQ-003 The block SHALL have parameter LEVELS, default 4, meaning the number of speed levels (range 2..15).
REQ-004 The block SHALL have parameter TICK_DIV, default 416667, meaning clk cycles per slot tick (about 240 Hz at 100 MHz; range >= 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the 100 MHz system clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: when low, all pulse generation is suppressed.
REQ-008 The block SHALL have port accel_in, input, CH*W bits: channel c occupies bits [c*W+W-1 : c*W].
REQ-009 The block SHALL have port sens, input, 2 bits: sensitivity; the level shift is 3+sens.
REQ-010 The block SHALL have port btn_pos, input, CH bits: per-channel positive-direction override, debounced, active high.
REQ-011 The block SHALL have port btn_neg, input, CH bits: per-channel negative-direction override, debounced, active high.
REQ-012 The block SHALL have port pulse_pos, output, CH bits: one-cycle move pulse in the positive direction.
REQ-013 The block SHALL have port pulse_neg, output, CH bits: one-cycle move pulse in the negative direction.
REQ-014 The block SHALL have port level_out, output, CH*4 bits: per-channel registered current level, 0..LEVELS.
REQ-015 The block SHALL have port slot_tick, output, 1 bit: one-cycle strobe, asserted once per TICK_DIV cycles.

Function
REQ-016 Prescaler: the counter SHALL run 0..TICK_DIV-1 and wrap to 0; slot_tick SHALL be asserted in the cycle where the counter equals TICK_DIV-1.
REQ-017 The prescaler SHALL run regardless of enable.
REQ-018 Raw level per channel SHALL be min(LEVELS, magnitude >> (3+sens)); magnitude 0 (including negative zero) SHALL give level 0.
REQ-019 Button override:
  - exactly one of btn_pos[c] or btn_neg[c] high: channel c SHALL use level LEVELS in that button's direction, ignoring accel_in.
  - both high or both low: accel_in SHALL be used.
REQ-020 Effective level and direction SHALL be sampled only on slot_tick cycles; level_out SHALL update in the cycle after the sampling tick.
REQ-021 Each channel SHALL hold an accumulator acc of width 4 bits. On each slot tick with enable high and level L > 0:
  - if acc + L >= LEVELS, then acc <= acc + L - LEVELS and a pulse is emitted;
  - otherwise acc <= acc + L and no pulse is emitted.
REQ-022 Resulting pulse rate SHALL be L/LEVELS of the slot-tick rate: level LEVELS gives one pulse every tick; level 1 gives one pulse every LEVELS ticks.
REQ-023 Level 0 on a slot tick SHALL clear acc to 0 and emit no pulse.
REQ-024 A direction change, i.e. the sampled sign differs from the previously sampled sign with L > 0, SHALL clear acc to 0 before the add in that same tick.
REQ-025 Pulses SHALL be registered, asserted exactly one cycle after the slot_tick cycle, and high for exactly one cycle.
REQ-026 pulse_pos[c] and pulse_neg[c] SHALL never both be high.
REQ-027 enable low SHALL force all accumulators to 0 and all pulses low; level_out SHALL continue to update.
REQ-028 Channels SHALL be fully independent; simultaneous pulses on different channels SHALL be permitted.

Reset
REQ-029 With reset high on a clk edge, the following SHALL all be 0 after that edge: prescaler, acc, stored direction, pulse_pos, pulse_neg, level_out, slot_tick.
REQ-030 Reset asserted mid-operation SHALL take effect on the next edge, discarding any pending accumulation.
REQ-031 The first slot_tick after reset deassertion SHALL occur TICK_DIV cycles after the first non-reset edge.

Verification (TICK_DIV=4, CH=2, LEVELS=4, W=9)
REQ-032 With sens=0 and ch0 = +0x40 (level 4): pulse_pos[0] SHALL occur every 4 cycles, one cycle after each slot_tick, and level_out[3:0] SHALL be 4.
REQ-033 With sens=0 and ch0 = +0x08 (level 1): pulse_pos[0] SHALL occur once per 4 slot ticks, i.e. every 16 cycles.
REQ-034 With sens=0, ch1 = -0x10 (level 2) and btn_pos[1]=1 held: pulse_pos[1] SHALL occur on every tick and pulse_neg[1] SHALL never occur; with both buttons high, pulse_neg[1] SHALL occur every 2nd tick.
REQ-035 With ch0 at level 3 after one tick (acc=3), switch the input to -level 3: no pulse SHALL occur on the next tick (acc cleared, then acc=3), and pulse_neg[0] SHALL occur on the following tick.
REQ-036 Drop enable for 10 cycles mid-stream, then raise it: no pulses SHALL occur while enable is low, and acc SHALL restart from 0.
REQ-037 Assert reset for 1 cycle mid-stream: all outputs SHALL be 0 on the next edge, and the first slot_tick SHALL occur 4 cycles after release.
